// File: rtl/miriscv_pkg.sv
// Shared types for the miriscv memory-side blocks.
// arb_state_e : owner of the single outstanding memory transaction
//               (IDLE, instruction, data, or a killed instruction still in flight).
// arb_src_e   : identifies one of the two requesters of the memory arbiter.
package miriscv_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_WAIT_I,
        ARB_WAIT_D,
        ARB_WAIT_DROP
    } arb_state_e;

    typedef enum logic {
        ARB_SRC_INSTR,
        ARB_SRC_DATA
    } arb_src_e;

endpackage

// File: rtl/miriscv_arb_pick2.sv
// Combinational two-way picker for the memory arbiter.
// Ports:
//   instr_elig_i : instruction requester is eligible this cycle
//   data_elig_i  : data requester is eligible this cycle
//   last_i       : requester that won the previous grant
//   winner_o     : selected requester (only meaningful when valid_o is 1)
//   valid_o      : at least one requester is eligible
// RR_EN = 1 alternates on a tie (the one that did not win last time);
// RR_EN = 0 always gives a tie to the data side.
module miriscv_arb_pick2
    import miriscv_pkg::*;
#(
    parameter int unsigned RR_EN = 1
) (
    input  logic     instr_elig_i,
    input  logic     data_elig_i,
    input  arb_src_e last_i,
    output arb_src_e winner_o,
    output logic     valid_o
);

    always_comb begin
        valid_o  = instr_elig_i || data_elig_i;
        winner_o = ARB_SRC_INSTR;
        if (instr_elig_i && data_elig_i) begin
            if (RR_EN != 0) begin
                winner_o = (last_i == ARB_SRC_INSTR) ? ARB_SRC_DATA : ARB_SRC_INSTR;
            end else begin
                winner_o = ARB_SRC_DATA;
            end
        end else if (data_elig_i) begin
            winner_o = ARB_SRC_DATA;
        end
    end

endmodule

// File: rtl/miriscv_mem_arbiter.sv
// Shares one single-outstanding memory port between instruction fetch and
// the LSU. The memory has no grant: a request is taken in the cycle mem_req_o
// is high and answered by mem_rvalid_i one or more cycles later.
// Ports:
//   clk_i, arstn_i              : clock, asynchronous active-low reset
//   instr_req_i/addr/flush      : fetch request (level) and pipeline flush
//   instr_rvalid_o/rdata_o      : fetch response
//   data_req/we/be/addr/wdata_i : LSU request (level)
//   data_rvalid_o/rdata_o       : LSU response
//   mem_req/we/be/addr/wdata_o  : memory request, one-cycle pulse per transaction
//   mem_rvalid_i/rdata_i        : memory response
module miriscv_mem_arbiter
    import miriscv_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned RR_EN = 1
) (
    input  logic              clk_i,
    input  logic              arstn_i,

    input  logic              instr_req_i,
    input  logic [XLEN-1:0]   instr_addr_i,
    input  logic              instr_flush_i,
    output logic              instr_rvalid_o,
    output logic [XLEN-1:0]   instr_rdata_o,

    input  logic              data_req_i,
    input  logic              data_we_i,
    input  logic [XLEN/8-1:0] data_be_i,
    input  logic [XLEN-1:0]   data_addr_i,
    input  logic [XLEN-1:0]   data_wdata_i,
    output logic              data_rvalid_o,
    output logic [XLEN-1:0]   data_rdata_o,

    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [XLEN/8-1:0] mem_be_o,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic              mem_rvalid_i,
    input  logic [XLEN-1:0]   mem_rdata_i
);

    arb_state_e state_ff;
    arb_src_e   rr_last_ff;

    logic     free;
    logic     instr_elig;
    logic     pick_valid;
    logic     grant;
    arb_src_e pick_winner;

    // The port is free when nothing is outstanding, or when the outstanding
    // transaction completes this cycle (back-to-back issue without a bubble).
    assign free       = (state_ff == ARB_IDLE) || mem_rvalid_i;
    assign instr_elig = instr_req_i && !instr_flush_i;

    miriscv_arb_pick2 #(
        .RR_EN (RR_EN)
    ) u_pick (
        .instr_elig_i (instr_elig),
        .data_elig_i  (data_req_i),
        .last_i       (rr_last_ff),
        .winner_o     (pick_winner),
        .valid_o      (pick_valid)
    );

    // Gated by reset so that no request leaks out combinationally while the
    // block is held in reset.
    assign grant = pick_valid && free && arstn_i;

    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (grant) begin
            mem_req_o = 1'b1;
            if (pick_winner == ARB_SRC_DATA) begin
                mem_we_o    = data_we_i;
                mem_be_o    = data_be_i;
                mem_addr_o  = data_addr_i;
                mem_wdata_o = data_wdata_i;
            end else begin
                mem_be_o    = '1;
                mem_addr_o  = instr_addr_i;
            end
        end
    end

    // A flush in the response cycle of a fetch drops that response.
    assign instr_rvalid_o = mem_rvalid_i && (state_ff == ARB_WAIT_I) && !instr_flush_i;
    assign data_rvalid_o  = mem_rvalid_i && (state_ff == ARB_WAIT_D);
    assign instr_rdata_o  = instr_rvalid_o ? mem_rdata_i : '0;
    assign data_rdata_o   = data_rvalid_o  ? mem_rdata_i : '0;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_ff   <= ARB_IDLE;
            rr_last_ff <= ARB_SRC_DATA;
        end else if (grant) begin
            rr_last_ff <= pick_winner;
            state_ff   <= (pick_winner == ARB_SRC_DATA) ? ARB_WAIT_D : ARB_WAIT_I;
        end else begin
            case (state_ff)
                ARB_WAIT_I: begin
                    if (mem_rvalid_i) begin
                        state_ff <= ARB_IDLE;
                    end else if (instr_flush_i) begin
                        // Fetch killed while in flight: absorb its response later.
                        state_ff <= ARB_WAIT_DROP;
                    end
                end
                ARB_WAIT_D, ARB_WAIT_DROP: begin
                    if (mem_rvalid_i) begin
                        state_ff <= ARB_IDLE;
                    end
                end
                default: state_ff <= ARB_IDLE;
            endcase
        end
    end

    a_req_only_when_free: assert property (@(posedge clk_i) disable iff (!arstn_i)
        mem_req_o |-> free);
    a_rvalid_exclusive: assert property (@(posedge clk_i) disable iff (!arstn_i)
        !(instr_rvalid_o && data_rvalid_o));
    a_rvalid_from_mem: assert property (@(posedge clk_i) disable iff (!arstn_i)
        (instr_rvalid_o || data_rvalid_o) |-> mem_rvalid_i);
    // Protocol error by the memory: a response with nothing outstanding.
    // It is ignored by the logic; this records that it happened.
    c_rvalid_in_idle: cover property (@(posedge clk_i) disable iff (!arstn_i)
        (state_ff == ARB_IDLE) && mem_rvalid_i);

endmodule

// File: tb/tb_miriscv_mem_arbiter.sv
// Two arbiters run side by side on identical stimulus: dut 0 round-robin,
// dut 1 fixed priority. Expected events are queued per dut with the cycle
// they must appear in; a negedge monitor matches what each dut presents.
module tb_miriscv_mem_arbiter;

    localparam int K_REQ  = 0;
    localparam int K_IRSP = 1;
    localparam int K_DRSP = 2;

    typedef struct {
        int          dut;
        int          cyc;
        int          kind;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } ev_t;

    logic        clk = 1'b0;
    logic        arstn;
    logic        instr_req, instr_flush, data_req, data_we, mem_rvalid;
    logic [31:0] instr_addr, data_addr, data_wdata, mem_rdata;
    logic [3:0]  data_be;

    logic        instr_rvalid [2];
    logic [31:0] instr_rdata  [2];
    logic        data_rvalid  [2];
    logic [31:0] data_rdata   [2];
    logic        mem_req      [2];
    logic        mem_we       [2];
    logic [3:0]  mem_be       [2];
    logic [31:0] mem_addr     [2];
    logic [31:0] mem_wdata    [2];

    int  cyc = 0;
    int  n_checks = 0;
    int  n_errors = 0;
    ev_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    miriscv_mem_arbiter #(.XLEN(32), .RR_EN(1)) dut_rr (
        .clk_i(clk), .arstn_i(arstn),
        .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_flush_i(instr_flush),
        .instr_rvalid_o(instr_rvalid[0]), .instr_rdata_o(instr_rdata[0]),
        .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be),
        .data_addr_i(data_addr), .data_wdata_i(data_wdata),
        .data_rvalid_o(data_rvalid[0]), .data_rdata_o(data_rdata[0]),
        .mem_req_o(mem_req[0]), .mem_we_o(mem_we[0]), .mem_be_o(mem_be[0]),
        .mem_addr_o(mem_addr[0]), .mem_wdata_o(mem_wdata[0]),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
    );

    miriscv_mem_arbiter #(.XLEN(32), .RR_EN(0)) dut_fp (
        .clk_i(clk), .arstn_i(arstn),
        .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_flush_i(instr_flush),
        .instr_rvalid_o(instr_rvalid[1]), .instr_rdata_o(instr_rdata[1]),
        .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be),
        .data_addr_i(data_addr), .data_wdata_i(data_wdata),
        .data_rvalid_o(data_rvalid[1]), .data_rdata_o(data_rdata[1]),
        .mem_req_o(mem_req[1]), .mem_we_o(mem_we[1]), .mem_be_o(mem_be[1]),
        .mem_addr_o(mem_addr[1]), .mem_wdata_o(mem_wdata[1]),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
    );

    function automatic string kname(int kind);
        if (kind == K_REQ)  return "req";
        if (kind == K_IRSP) return "instr_rsp";
        return "data_rsp";
    endfunction

    // ---------------- expectation helpers ----------------
    task automatic exp_req(int d, logic [31:0] a, logic we, logic [3:0] be, logic [31:0] wd);
        ev_t e;
        e.dut = d; e.cyc = cyc; e.kind = K_REQ;
        e.addr = a; e.we = we; e.be = be; e.wdata = wd; e.rdata = '0;
        exp_q.push_back(e);
    endtask

    task automatic exp_ireq(int d, logic [31:0] a);
        exp_req(d, a, 1'b0, 4'hF, 32'h0);
    endtask

    task automatic exp_rsp(int d, int kind, logic [31:0] rd);
        ev_t e;
        e.dut = d; e.cyc = cyc; e.kind = kind;
        e.addr = '0; e.we = 1'b0; e.be = '0; e.wdata = '0; e.rdata = rd;
        exp_q.push_back(e);
    endtask

    // ---------------- monitor ----------------
    task automatic match_ev(int d, int kind, logic [31:0] a, logic we, logic [3:0] be,
                            logic [31:0] wd, logic [31:0] rd);
        int  idx;
        ev_t e;
        bit  bad;
        idx = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (idx < 0 && exp_q[i].dut == d && exp_q[i].cyc == cyc && exp_q[i].kind == kind)
                idx = i;
        end
        n_checks++;
        if (idx < 0) begin
            n_errors++;
            $display("FAIL unexpected_%s dut%0d cyc %0d: got addr=%h we=%b be=%h wdata=%h rdata=%h, required no event",
                     kname(kind), d, cyc, a, we, be, wd, rd);
            return;
        end
        e = exp_q[idx];
        exp_q.delete(idx);
        if (kind == K_REQ)
            bad = (a !== e.addr) || (we !== e.we) || (be !== e.be) || (wd !== e.wdata);
        else
            bad = (rd !== e.rdata);
        if (bad) begin
            n_errors++;
            $display("FAIL %s dut%0d cyc %0d: got addr=%h we=%b be=%h wdata=%h rdata=%h, required addr=%h we=%b be=%h wdata=%h rdata=%h",
                     kname(kind), d, cyc, a, we, be, wd, rd, e.addr, e.we, e.be, e.wdata, e.rdata);
        end else begin
            $display("ok   %s dut%0d cyc %0d addr=%h we=%b be=%h wdata=%h rdata=%h",
                     kname(kind), d, cyc, a, we, be, wd, rd);
        end
    endtask

    task automatic check_dut(int d);
        if (instr_rvalid[d])
            match_ev(d, K_IRSP, '0, 1'b0, '0, '0, instr_rdata[d]);
        if (data_rvalid[d])
            match_ev(d, K_DRSP, '0, 1'b0, '0, '0, data_rdata[d]);
        if (mem_req[d])
            match_ev(d, K_REQ, mem_addr[d], mem_we[d], mem_be[d], mem_wdata[d], '0);
        // Anything still expected for this cycle or earlier never appeared.
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].dut == d && exp_q[i].cyc <= cyc) begin
                n_checks++;
                n_errors++;
                $display("FAIL missing_%s dut%0d cyc %0d: got nothing, required addr=%h rdata=%h",
                         kname(exp_q[i].kind), d, exp_q[i].cyc, exp_q[i].addr, exp_q[i].rdata);
                exp_q.delete(i);
            end
        end
        // Quiet outputs must read as zero; the two rvalids are exclusive.
        n_checks++;
        if ((!mem_req[d] && ({mem_we[d], mem_be[d], mem_addr[d], mem_wdata[d]} != '0)) ||
            (!instr_rvalid[d] && instr_rdata[d] != '0) ||
            (!data_rvalid[d] && data_rdata[d] != '0) ||
            (instr_rvalid[d] && data_rvalid[d])) begin
            n_errors++;
            $display("FAIL idle_zero dut%0d cyc %0d: got req=%b addr=%h ird=%h drd=%h iv=%b dv=%b, required zero when not valid",
                     d, cyc, mem_req[d], mem_addr[d], instr_rdata[d], data_rdata[d],
                     instr_rvalid[d], data_rvalid[d]);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) check_dut(d);
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        instr_req = 1'b0; instr_addr = '0; instr_flush = 1'b0;
        data_req = 1'b0; data_we = 1'b0; data_be = '0; data_addr = '0; data_wdata = '0;
        mem_rvalid = 1'b0; mem_rdata = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        arstn = 1'b0;
        step();
        step();
        arstn = 1'b1;
    endtask

    // Owner of the k-th back-to-back grant in the arbitration test.
    function automatic int owner(int d, int k);
        if (k >= 4) return K_IRSP;
        if (d == 0) return (k % 2 == 0) ? K_IRSP : K_DRSP;
        return K_DRSP;
    endfunction

    initial begin
        clear_inputs();
        arstn = 1'b0;
        step();
        step();
        for (int d = 0; d < 2; d++) begin
            n_checks++;
            if (mem_req[d] !== 1'b0 || instr_rvalid[d] !== 1'b0 || data_rvalid[d] !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_outputs dut%0d: got req=%b iv=%b dv=%b, required 0 0 0",
                         d, mem_req[d], instr_rvalid[d], data_rvalid[d]);
            end
        end
        arstn = 1'b1;

        // Single fetch, latency 1.
        step();
        instr_req = 1'b1; instr_addr = 32'h0000_0100;
        exp_ireq(0, 32'h100); exp_ireq(1, 32'h100);
        step();
        instr_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0013;
        exp_rsp(0, K_IRSP, 32'h13); exp_rsp(1, K_IRSP, 32'h13);
        step();
        clear_inputs();

        // Both requesters held, latency 1: RR alternates, fixed keeps data.
        do_reset();
        step();
        instr_req = 1'b1; instr_addr = 32'h0000_0300;
        data_req = 1'b1; data_we = 1'b1; data_be = 4'hC;
        data_addr = 32'h0000_1000; data_wdata = 32'h1234_5678;
        for (int d = 0; d < 2; d++) begin
            if (owner(d, 0) == K_IRSP) exp_ireq(d, 32'h300);
            else exp_req(d, 32'h1000, 1'b1, 4'hC, 32'h1234_5678);
        end
        for (int k = 1; k <= 5; k++) begin
            step();
            mem_rvalid = 1'b1; mem_rdata = 32'hA000_0000 + k;
            if (k == 4) data_req = 1'b0;
            if (k == 5) instr_req = 1'b0;
            for (int d = 0; d < 2; d++) begin
                exp_rsp(d, owner(d, k - 1), 32'hA000_0000 + k);
                if (k <= 4) begin
                    if (owner(d, k) == K_IRSP) exp_ireq(d, 32'h300);
                    else exp_req(d, 32'h1000, 1'b1, 4'hC, 32'h1234_5678);
                end
            end
        end
        step();
        clear_inputs();

        // Fetch killed in flight (latency 3); the next fetch issues in the drop cycle.
        step();
        instr_req = 1'b1; instr_addr = 32'h0000_0200;
        exp_ireq(0, 32'h200); exp_ireq(1, 32'h200);
        step();
        instr_flush = 1'b1;
        step();
        instr_flush = 1'b0; instr_addr = 32'h0000_0400;
        step();
        mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        exp_ireq(0, 32'h400); exp_ireq(1, 32'h400);
        step();
        instr_req = 1'b0; mem_rdata = 32'h0000_0093;
        exp_rsp(0, K_IRSP, 32'h93); exp_rsp(1, K_IRSP, 32'h93);
        step();
        clear_inputs();

        // Flush in the same cycle as the fetch response drops it.
        step();
        instr_req = 1'b1; instr_addr = 32'h0000_0500;
        exp_ireq(0, 32'h500); exp_ireq(1, 32'h500);
        step();
        instr_flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0077;
        step();
        clear_inputs();

        // LSU write with flush held throughout the wait: flush has no effect.
        step();
        data_req = 1'b1; data_we = 1'b1; data_be = 4'b0011;
        data_addr = 32'h0000_1000; data_wdata = 32'hCAFE_F00D;
        exp_req(0, 32'h1000, 1'b1, 4'b0011, 32'hCAFE_F00D);
        exp_req(1, 32'h1000, 1'b1, 4'b0011, 32'hCAFE_F00D);
        step();
        instr_flush = 1'b1;
        step();
        step();
        data_req = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h5555_AAAA;
        exp_rsp(0, K_DRSP, 32'h5555_AAAA); exp_rsp(1, K_DRSP, 32'h5555_AAAA);
        step();
        clear_inputs();

        // Reset while in WAIT_D, spurious response after release, then a tie.
        step();
        data_req = 1'b1; data_be = 4'hF; data_addr = 32'h0000_2000;
        exp_req(0, 32'h2000, 1'b0, 4'hF, 32'h0); exp_req(1, 32'h2000, 1'b0, 4'hF, 32'h0);
        step();
        arstn = 1'b0; data_req = 1'b0;
        step();
        step();
        arstn = 1'b1;
        step();
        mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        step();
        mem_rvalid = 1'b0; mem_rdata = '0;
        instr_req = 1'b1; instr_addr = 32'h0000_0600;
        data_req = 1'b1; data_we = 1'b0; data_be = 4'hF; data_addr = 32'h0000_3000;
        exp_ireq(0, 32'h600);
        exp_req(1, 32'h3000, 1'b0, 4'hF, 32'h0);
        step();
        instr_req = 1'b0; data_req = 1'b0;
        mem_rvalid = 1'b1; mem_rdata = 32'h0000_600D;
        exp_rsp(0, K_IRSP, 32'h600D);
        exp_rsp(1, K_DRSP, 32'h600D);
        step();
        clear_inputs();
        step();
        step();

        while (exp_q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL leftover_%s dut%0d cyc %0d: got nothing, required addr=%h rdata=%h",
                     kname(exp_q[0].kind), exp_q[0].dut, exp_q[0].cyc, exp_q[0].addr, exp_q[0].rdata);
            void'(exp_q.pop_front());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
